// File: rtl/updown_counter_pkg.sv
// Shared constants for updown_counter: default width and direction encoding.
// No logic, no latency, no backpressure.
package updown_counter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/updown_counter_next.sv
// Combinational step logic: count +/- 1 mod 2^WIDTH plus the "this step wraps" flag.
// Zero latency, no backpressure.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             U_D,
  output logic [WIDTH-1:0] count_step,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    count_step = count;
    wrap       = 1'b0;
    if (U_D == DIR_UP) begin
      count_step = count + ONE;
      wrap       = (count == '1);
    end else begin
      count_step = count - ONE;
      wrap       = (count == '0);
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Loadable up/down counter, priority reset_n > ld > step, wraps mod 2^WIDTH; tc port only with UPDOWN_COUNTER_TC_EN.
// Count updates one cycle after sampling; no backpressure, steps every non-reset non-load cycle.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic             U_D,
  input  logic [WIDTH-1:0] data_in,
`ifdef UPDOWN_COUNTER_TC_EN
  output logic             tc,
`endif
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_step;

`ifdef UPDOWN_COUNTER_TC_EN
  logic step_wrap;
`else
  logic step_wrap_unused;
`endif

  updown_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .count      (count_q),
    .U_D        (U_D),
    .count_step (count_step),
`ifdef UPDOWN_COUNTER_TC_EN
    .wrap       (step_wrap)
`else
    .wrap       (step_wrap_unused)
`endif
  );

  // reset_n is active-high despite its name
  always_comb begin
    count_d = count_q;
    if (reset_n) begin
      count_d = '0;
    end else if (ld) begin
      count_d = data_in;
    end else begin
      count_d = count_step;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

`ifdef UPDOWN_COUNTER_TC_EN
  // tc looks only at count and direction, so it flags a wrap even on load/reset cycles
  assign tc = step_wrap;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter (WIDTH=3): reset, load, wrap both ways, priority, reversal.
module tb_updown_counter;

  logic       clk;
  logic       reset_n;
  logic       ld;
  logic       U_D;
  logic [2:0] data_in;
  logic [2:0] count;
`ifdef UPDOWN_COUNTER_TC_EN
  logic       tc;
`endif

  int tests_run;
  int tests_failed;
  logic [2:0] prev_exp;
  bit         prev_known;

  updown_counter #(
    .WIDTH(3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (ld),
    .U_D     (U_D),
    .data_in (data_in),
`ifdef UPDOWN_COUNTER_TC_EN
    .tc      (tc),
`endif
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, check tc against the current count, then check count after the edge.
  task automatic step(input logic rst, input logic l, input logic ud,
                      input logic [2:0] din, input logic [2:0] exp_count,
                      input string tag);
    reset_n = rst;
    ld      = l;
    U_D     = ud;
    data_in = din;
`ifdef UPDOWN_COUNTER_TC_EN
    if (prev_known) begin
      logic exp_tc;
      #1;
      exp_tc = (ud && prev_exp == 3'd7) || (!ud && prev_exp == 3'd0);
      tests_run++;
      assert (tc === exp_tc)
      else begin
        tests_failed++;
        $error("FAIL %s_tc: tc=%b expected %b", tag, tc, exp_tc);
      end
    end
`endif
    @(posedge clk);
    #1;
    tests_run++;
    assert (count === exp_count)
    else begin
      tests_failed++;
      $error("FAIL %s: count=%0d expected %0d", tag, count, exp_count);
    end
    prev_exp   = exp_count;
    prev_known = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    prev_exp     = 3'd0;
    prev_known   = 1'b0;
    reset_n      = 1'b1;
    ld           = 1'b0;
    U_D          = 1'b1;
    data_in      = 3'd0;

    //   rst   ld    ud    din   exp
    step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, "reset");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd1, "up1");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd2, "up2");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd3, "up3");
    step(1'b1, 1'b0, 1'b1, 3'd6, 3'd0, "reset_midcount");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd1, "after_reset1");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd2, "after_reset2");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd3, "after_reset3");

    step(1'b0, 1'b1, 1'b1, 3'd5, 3'd5, "load5");
    step(1'b0, 1'b1, 1'b1, 3'd2, 3'd2, "load2");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd3, "step_after_load");
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd2, "reverse_down");

    step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, "load0");
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd7, "down_wrap");
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd6, "down6");
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd5, "down5");
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd4, "down4");

    step(1'b0, 1'b1, 1'b1, 3'd6, 3'd6, "load6");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd7, "up7");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, "up_wrap");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd1, "up_after_wrap");

    step(1'b1, 1'b1, 1'b1, 3'd5, 3'd0, "reset_over_load");
    step(1'b0, 1'b1, 1'b1, 3'd4, 3'd4, "load_over_up");
    step(1'b0, 1'b1, 1'b0, 3'd4, 3'd4, "load_over_down");
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd3, "down_after_load");
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd4, "reverse_up");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
